bitbakery_tx_serial_8e1: RTL and testbench

BITBAKERY_TX_SERIAL_8E1 -- requirements
Module: bitbakery_tx_serial_8e1

---
 rtl/bitbakery_tx_serial_8e1_pkg.sv | 29 ++
 rtl/bitbakery_tx_serial_8e1_contador_tick.sv | 46 ++++
 rtl/bitbakery_tx_serial_8e1.sv | 113 +++++++++++
 tb/tb_bitbakery_tx_serial_8e1.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bitbakery_tx_serial_8e1_pkg.sv
// ============================================================================
// Module   : bitbakery_tx_serial_8e1_pkg
// Purpose  : Shared state encodings, frame constants and parity helper for
//            the 8E1 serial transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bitbakery_tx_serial_8e1_pkg;

    typedef enum logic [1:0] {
        ST_INICIAL     = 2'b00,
        ST_PREPARACAO  = 2'b01,
        ST_TRANSMISSAO = 2'b10,
        ST_FINAL       = 2'b11
    } estado_t;

    localparam int FRAME_BITS           = 11;
    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int BIT_CNT_W            = 4;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic paridade_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitbakery_tx_serial_8e1_contador_tick.sv
// ============================================================================
// Module   : bitbakery_contador_tick
// Purpose  : Modulo-M cycle counter producing a one-cycle tick at count M-1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bitbakery_contador_tick #(
    parameter int M = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int              W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0]    LAST = W'(M - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tick_o = enable_i && (count_q == LAST);

    // Wraps to zero on the tick itself, so the count never exceeds M-1.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = tick_o ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bitbakery_tx_serial_8e1.sv
// ============================================================================
// Module   : bitbakery_tx_serial_8e1
// Purpose  : 8E1 serial transmitter (start, 8 data LSB first, even parity,
//            stop). Optional debug ports under BITBAKERY_TX_SERIAL_DEBUG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bitbakery_tx_serial_8e1
    import bitbakery_tx_serial_8e1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto
`ifdef BITBAKERY_TX_SERIAL_DEBUG_EN
    ,
    output logic [1:0] db_estado,
    output logic       db_tick
`endif
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    estado_t                  estado_q, estado_d;
    logic [7:0]               dados_q, dados_d;
    logic [FRAME_BITS-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                     cnt_clear;
    logic                     cnt_enable;
    logic                     tick;

    bitbakery_contador_tick #(
        .M (CLKS_PER_BIT)
    ) u_contador_tick (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .tick_o   (tick)
    );

    always_comb begin
        estado_d   = estado_q;
        dados_d    = dados_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        pronto     = 1'b0;
        case (estado_q)
            ST_INICIAL: begin
                if (partida) begin
                    dados_d  = dados;
                    estado_d = ST_PREPARACAO;
                end
            end
            ST_PREPARACAO: begin
                shift_d   = {1'b1, paridade_par(dados_q), dados_q, 1'b0};
                bit_cnt_d = '0;
                cnt_clear = 1'b1;
                estado_d  = ST_TRANSMISSAO;
            end
            ST_TRANSMISSAO: begin
                cnt_enable = 1'b1;
                // Last bit period ends without incrementing, so the counter stops at 10.
                if (tick) begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        estado_d = ST_FINAL;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_FINAL: begin
                pronto   = 1'b1;
                estado_d = ST_INICIAL;
            end
            default: begin
                estado_d = ST_INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= ST_INICIAL;
            dados_q   <= '0;
            shift_q   <= '1;
            bit_cnt_q <= '0;
        end else begin
            estado_q  <= estado_d;
            dados_q   <= dados_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign saida_serial = (estado_q == ST_TRANSMISSAO) ? shift_q[0] : 1'b1;

`ifdef BITBAKERY_TX_SERIAL_DEBUG_EN
    assign db_estado = estado_q;
    assign db_tick   = tick;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitbakery_tx_serial_8e1.sv
// ============================================================================
// Module   : tb_bitbakery_tx_serial_8e1
// Purpose  : Directed self-checking bench for the 8E1 transmitter, CLKS_PER_BIT=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bitbakery_tx_serial_8e1;

    localparam int CPB = 4;

    logic       clock;
    logic       reset;
    logic       partida;
    logic [7:0] dados;
    logic       saida_serial;
    logic       pronto;
`ifdef BITBAKERY_TX_SERIAL_DEBUG_EN
    logic [1:0] db_estado;
    logic       db_tick;
`endif

    int passed = 0;
    int total  = 0;

    bitbakery_tx_serial_8e1 #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .dados        (dados),
        .saida_serial (saida_serial),
        .pronto       (pronto)
`ifdef BITBAKERY_TX_SERIAL_DEBUG_EN
        ,
        .db_estado    (db_estado),
        .db_tick      (db_tick)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at the negedge before accepting edge k; returns at the negedge after k+46.
    // exp[i] is the i-th bit on the line, start bit first.
    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp,
                             input bit keep, input bit disturb, input string name);
        partida = 1'b1;
        dados   = d;
        @(negedge clock);
        if (!keep) partida = 1'b0;
        total++;
        if (saida_serial !== 1'b1 || pronto !== 1'b0)
            $display("FAIL %s prep: saida=%b pronto=%b, want 1/0", name, saida_serial, pronto);
        else passed++;
        for (int n = 0; n < 11 * CPB; n++) begin
            @(negedge clock);
            if (disturb) begin
                if (n == 6 || n == 30) partida = 1'b1;
                else if (!keep) partida = 1'b0;
                if (n == 20) dados = 8'hAA;
            end
            total++;
            if (saida_serial !== exp[n / CPB] || pronto !== 1'b0)
                $display("FAIL %s bit%0d cyc%0d: saida=%b pronto=%b, want %b/0",
                         name, n / CPB, n % CPB, saida_serial, pronto, exp[n / CPB]);
            else passed++;
        end
        @(negedge clock);
        total++;
        if (pronto !== 1'b1 || saida_serial !== 1'b1)
            $display("FAIL %s final: pronto=%b saida=%b, want 1/1", name, pronto, saida_serial);
        else passed++;
        @(negedge clock);
        total++;
        if (pronto !== 1'b0 || saida_serial !== 1'b1)
            $display("FAIL %s after_final: pronto=%b saida=%b, want 0/1", name, pronto, saida_serial);
        else passed++;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        partida = 1'b1;
        dados   = 8'h3C;
        repeat (3) @(negedge clock);
        total++;
        if (saida_serial !== 1'b1 || pronto !== 1'b0)
            $display("FAIL reset_state: saida=%b pronto=%b, want 1/0", saida_serial, pronto);
        else passed++;
        reset   = 1'b0;
        partida = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (saida_serial !== 1'b1 || pronto !== 1'b0)
            $display("FAIL idle_after_reset: saida=%b pronto=%b, want 1/0", saida_serial, pronto);
        else passed++;
    endtask

    task automatic test_frame_41();
        run_frame(8'h41, 11'b10010000010, 1'b0, 1'b0, "frame41");
        repeat (2) @(negedge clock);
    endtask

    task automatic test_parity();
        run_frame(8'h07, 11'b11000001110, 1'b0, 1'b0, "par07");
        run_frame(8'h00, 11'b10000000000, 1'b0, 1'b0, "par00");
        run_frame(8'hFF, 11'b10111111110, 1'b0, 1'b0, "parFF");
    endtask

    task automatic test_ignore_inputs();
        run_frame(8'h41, 11'b10010000010, 1'b0, 1'b1, "ignore");
        dados = 8'h00;
        repeat (3) @(negedge clock);
        total++;
        if (saida_serial !== 1'b1 || pronto !== 1'b0)
            $display("FAIL ignore_no_extra_frame: saida=%b pronto=%b, want 1/0", saida_serial, pronto);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit seen_pronto = 1'b0;
        bit line_low    = 1'b0;
        partida = 1'b1;
        dados   = 8'h41;
        @(negedge clock);
        partida = 1'b0;
        repeat (26) @(negedge clock);
        total++;
        if (saida_serial !== 1'b0)
            $display("FAIL midframe_bit5: saida=%b, want 0", saida_serial);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (saida_serial !== 1'b1 || pronto !== 1'b0)
            $display("FAIL reset_async: saida=%b pronto=%b, want 1/0", saida_serial, pronto);
        else passed++;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (pronto !== 1'b0) seen_pronto = 1'b1;
            if (saida_serial !== 1'b1) line_low = 1'b1;
        end
        total++;
        if (seen_pronto || line_low)
            $display("FAIL abort_quiet: pronto_seen=%b line_low=%b, want 0/0", seen_pronto, line_low);
        else passed++;
        run_frame(8'h55, 11'b10010101010, 1'b0, 1'b0, "after_reset55");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h41, 11'b10010000010, 1'b1, 1'b0, "b2b_1");
        run_frame(8'h07, 11'b11000001110, 1'b1, 1'b0, "b2b_2");
        run_frame(8'hFF, 11'b10111111110, 1'b1, 1'b0, "b2b_3");
        partida = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset   = 1'b1;
        partida = 1'b0;
        dados   = 8'h00;
        @(negedge clock);
        test_reset();
        test_frame_41();
        test_parity();
        test_ignore_inputs();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
